word_copy: RTL and testbench



---
 rtl/word_copy_pkg.sv | 26 ++
 rtl/word_copy_regs.sv | 100 ++++++++++
 rtl/word_copy.sv | 135 +++++++++++++
 tb/tb_word_copy.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_copy_pkg.sv
// word_copy_pkg
// Shared definitions for the word-copy accelerator:
//   - FSM state encoding used by the top module
//   - slave register offsets used by the register file
//   - default byte stride between consecutive words
// Optional build macro: WORDCOPY_PROGRESS_EN (progress register at offset 4)
package word_copy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COPY_SOURCE_DATA,
    WAIT_SOURCE_DATAVALID,
    PASTE_SOURCE_DATA,
    CHECK_WORDS_LEFT,
    DONE
  } state_e;

  localparam logic [3:0] REG_START    = 4'd0;
  localparam logic [3:0] REG_DST      = 4'd1;
  localparam logic [3:0] REG_SRC      = 4'd2;
  localparam logic [3:0] REG_NUM      = 4'd3;
  localparam logic [3:0] REG_PROGRESS = 4'd4;

  localparam int unsigned WORD_BYTES_DEFAULT = 4;

endpackage

// File: rtl/word_copy_regs.sv
// word_copy_regs
// CPU-facing register file of the word-copy accelerator.
// Holds the programmed destination, source and word count, decodes the
// start strobe and produces the Avalon slave waitrequest/readdata.
// Optional build macro: WORDCOPY_PROGRESS_EN adds a progress_i port whose
// value is readable at offset 4 without stalling while busy.
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   idle_i                   copy engine is idle
//   progress_i               words completed so far (macro builds only)
//   slave_*_i / slave_*_o    Avalon-MM slave signals
//   start_o                  accepted write to the start register
//   dst_o, src_o, num_o      programmed copy parameters
module word_copy_regs
  import word_copy_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        idle_i,
`ifdef WORDCOPY_PROGRESS_EN
  input  logic [31:0] progress_i,
`endif
  input  logic [3:0]  slave_address_i,
  input  logic        slave_read_i,
  input  logic        slave_write_i,
  input  logic [31:0] slave_writedata_i,
  output logic        slave_waitrequest_o,
  output logic [31:0] slave_readdata_o,
  output logic        start_o,
  output logic [31:0] dst_o,
  output logic [31:0] src_o,
  output logic [31:0] num_o
);

  logic [31:0] dst_q, dst_d;
  logic [31:0] src_q, src_d;
  logic [31:0] num_q, num_d;
  logic        accessIdle;

  // While busy every access is held off until the engine returns to idle,
  // except a progress read when that register is built in.
`ifdef WORDCOPY_PROGRESS_EN
  assign slave_waitrequest_o = !idle_i && (slave_read_i || slave_write_i)
                               && (slave_address_i != REG_PROGRESS);
`else
  assign slave_waitrequest_o = !idle_i && (slave_read_i || slave_write_i);
`endif

  assign accessIdle = idle_i && slave_write_i;
  assign start_o    = accessIdle && (slave_address_i == REG_START);

  // Register updates happen only when idle; unmapped offsets are ignored.
  always_comb begin
    dst_d = dst_q;
    src_d = src_q;
    num_d = num_q;
    if (accessIdle) begin
      case (slave_address_i)
        REG_DST: dst_d = slave_writedata_i;
        REG_SRC: src_d = slave_writedata_i;
        REG_NUM: num_d = slave_writedata_i;
        default: ;
      endcase
    end
  end

  // Read data is zero unless a read completes this cycle.
  always_comb begin
    slave_readdata_o = '0;
    if (slave_read_i && !slave_waitrequest_o) begin
      case (slave_address_i)
        REG_START:    slave_readdata_o = {31'd0, !idle_i};
        REG_DST:      slave_readdata_o = dst_q;
        REG_SRC:      slave_readdata_o = src_q;
        REG_NUM:      slave_readdata_o = num_q;
`ifdef WORDCOPY_PROGRESS_EN
        REG_PROGRESS: slave_readdata_o = progress_i;
`endif
        default:      slave_readdata_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dst_q <= '0;
      src_q <= '0;
      num_q <= '0;
    end else begin
      dst_q <= dst_d;
      src_q <= src_d;
      num_q <= num_d;
    end
  end

  assign dst_o = dst_q;
  assign src_o = src_q;
  assign num_o = num_q;

endmodule

// File: rtl/word_copy.sv
// word_copy
// Memory-to-memory word-copy accelerator. A CPU programs destination,
// source and word count over the Avalon slave and writes offset 0 to start;
// the Avalon master then reads each source word and writes it to the
// destination, one read and one write per word, in ascending order.
// Optional build macro: WORDCOPY_PROGRESS_EN (offset 4 reads words done).
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   slave_*           Avalon-MM slave (CPU control/status)
//   master_*          Avalon-MM master (SDRAM access)
module word_copy
  import word_copy_pkg::*;
#(
  parameter int unsigned WORD_BYTES = WORD_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  state_e      state_q, state_d;
  logic [31:0] index_q, index_d;
  logic [31:0] data_q, data_d;
  logic [31:0] dstLat_q, dstLat_d;
  logic [31:0] srcLat_q, srcLat_d;
  logic [31:0] numLat_q, numLat_d;
  logic        start;
  logic [31:0] dstReg, srcReg, numReg;
  logic [31:0] wordOffset;

  word_copy_regs uRegs (
    .clk_i               (clk),
    .rst_i               (rst),
    .idle_i              (state_q == IDLE),
`ifdef WORDCOPY_PROGRESS_EN
    .progress_i          (index_q),
`endif
    .slave_address_i     (slave_address),
    .slave_read_i        (slave_read),
    .slave_write_i       (slave_write),
    .slave_writedata_i   (slave_writedata),
    .slave_waitrequest_o (slave_waitrequest),
    .slave_readdata_o    (slave_readdata),
    .start_o             (start),
    .dst_o               (dstReg),
    .src_o               (srcReg),
    .num_o               (numReg)
  );

  // Byte offset of the current word; wraps modulo 2^32 with the addresses.
  assign wordOffset = 32'(WORD_BYTES) * index_q;

  // Next-state logic. The copy parameters are snapshotted at start so the
  // CPU-visible registers never affect a copy already in flight.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    data_d   = data_q;
    dstLat_d = dstLat_q;
    srcLat_d = srcLat_q;
    numLat_d = numLat_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          index_d  = '0;
          dstLat_d = dstReg;
          srcLat_d = srcReg;
          numLat_d = numReg;
          state_d  = (numReg != '0) ? COPY_SOURCE_DATA : DONE;
        end
      end
      COPY_SOURCE_DATA: begin
        if (!master_waitrequest) state_d = WAIT_SOURCE_DATAVALID;
      end
      WAIT_SOURCE_DATAVALID: begin
        if (master_readdatavalid) begin
          data_d  = master_readdata;
          state_d = PASTE_SOURCE_DATA;
        end
      end
      PASTE_SOURCE_DATA: begin
        if (!master_waitrequest) state_d = CHECK_WORDS_LEFT;
      end
      CHECK_WORDS_LEFT: begin
        index_d = index_q + 32'd1;
        state_d = (index_q + 32'd1 == numLat_q) ? DONE : COPY_SOURCE_DATA;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Master strobes come straight from the state register so read and write
  // can never overlap.
  always_comb begin
    master_read    = (state_q == COPY_SOURCE_DATA);
    master_write   = (state_q == PASTE_SOURCE_DATA);
    master_address = '0;
    if (state_q == COPY_SOURCE_DATA)  master_address = srcLat_q + wordOffset;
    if (state_q == PASTE_SOURCE_DATA) master_address = dstLat_q + wordOffset;
  end

  assign master_writedata = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      index_q  <= '0;
      data_q   <= '0;
      dstLat_q <= '0;
      srcLat_q <= '0;
      numLat_q <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      data_q   <= data_d;
      dstLat_q <= dstLat_d;
      srcLat_q <= srcLat_d;
      numLat_q <= numLat_d;
    end
  end

endmodule

// File: tb/tb_word_copy.sv
// tb_word_copy
// Self-checking bench for word_copy: a table of idle register accesses,
// then directed copy sequences against a small SDRAM responder with
// programmable wait states and read latency.
module tb_word_copy;

  logic        clk = 1'b0;
  logic        rst;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;

  int errors = 0;
  int checks = 0;

  // SDRAM responder configuration and transaction logs
  int          stallCycles = 0;
  int          rdvDelay = 0;
  bit          fixedData = 1'b1;
  logic [31:0] rdLog[$];
  logic [31:0] wrAddrLog[$];
  logic [31:0] wrDataLog[$];

  typedef struct {
    logic        isWrite;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
  } vec_t;

  word_copy dut (
    .clk                  (clk),
    .rst                  (rst),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  always #5 clk = ~clk;

  // Compare one value and log a failure line when it differs.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Contents the SDRAM returns for a given byte address.
  function automatic logic [31:0] sdramData(input logic [31:0] a);
    return fixedData ? 32'hCDDDEEEF : {a[15:0], ~a[15:0]};
  endfunction

  // SDRAM responder: inserts stallCycles of waitrequest on every request,
  // returns read data rdvDelay cycles after the read is accepted, and checks
  // that a stalled request keeps its address, data and strobe stable.
  bit          pendValid = 1'b0;
  int          pendCd = 0;
  logic [31:0] pendAddr;
  int          waitCnt = 0;
  bit          holding = 1'b0;
  logic [31:0] holdAddr, holdData;
  logic        holdRd;

  initial begin
    master_waitrequest   = 1'b0;
    master_readdata      = '0;
    master_readdatavalid = 1'b0;
  end

  always @(negedge clk) begin
    master_readdatavalid = 1'b0;
    master_readdata      = '0;
    if (rst) begin
      pendValid          = 1'b0;
      waitCnt            = 0;
      holding            = 1'b0;
      master_waitrequest = 1'b0;
    end else begin
      if (pendValid) begin
        if (pendCd == 0) begin
          master_readdatavalid = 1'b1;
          master_readdata      = sdramData(pendAddr);
          pendValid            = 1'b0;
        end else begin
          pendCd--;
        end
      end
      if (master_read && master_write) begin
        checkOutput("strobeOverlap", {30'd0, master_read, master_write}, 32'd2);
      end
      if (master_read || master_write) begin
        if (holding) begin
          checkOutput("holdAddr", master_address, holdAddr);
          checkOutput("holdRead", {31'd0, master_read}, {31'd0, holdRd});
          if (!holdRd) checkOutput("holdData", master_writedata, holdData);
        end
        if (waitCnt < stallCycles) begin
          master_waitrequest = 1'b1;
          waitCnt++;
          holding  = 1'b1;
          holdAddr = master_address;
          holdData = master_writedata;
          holdRd   = master_read;
        end else begin
          master_waitrequest = 1'b0;
          waitCnt = 0;
          holding = 1'b0;
          if (master_read) begin
            rdLog.push_back(master_address);
            pendValid = 1'b1;
            pendCd    = rdvDelay;
            pendAddr  = master_address;
          end else begin
            wrAddrLog.push_back(master_address);
            wrDataLog.push_back(master_writedata);
          end
        end
      end else begin
        master_waitrequest = 1'b0;
        holding = 1'b0;
      end
    end
  end

  // CPU write; waits out any stall, then releases after the accepting edge.
  task automatic cpuWrite(input logic [3:0] addr, input logic [31:0] data);
    int k;
    @(negedge clk);
    slave_address   = addr;
    slave_writedata = data;
    slave_write     = 1'b1;
    #1;
    for (k = 0; k < 1000 && slave_waitrequest; k++) begin
      @(negedge clk);
      #1;
    end
    if (slave_waitrequest) checkOutput("writeTimeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    slave_write = 1'b0;
  endtask

  // CPU read; returns the data and how many cycles it was stalled.
  task automatic cpuRead(input logic [3:0] addr, output logic [31:0] data,
                         output int stalls);
    stalls = 0;
    @(negedge clk);
    slave_address = addr;
    slave_read    = 1'b1;
    #1;
    while (slave_waitrequest && stalls < 1000) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (slave_waitrequest) checkOutput("readTimeout", 32'd1, 32'd0);
    data = slave_readdata;
    @(posedge clk);
    #1;
    slave_read = 1'b0;
  endtask

  // Apply one table vector in idle; a read checks data and that it did not stall.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] rd;
    int          st;
    if (v.isWrite) begin
      cpuWrite(v.addr, v.wdata);
    end else begin
      cpuRead(v.addr, rd, st);
      checkOutput($sformatf("vec%0d_rdata", idx), rd, v.expRdata);
      checkOutput($sformatf("vec%0d_stall", idx), st, 32'd0);
    end
  endtask

  // Compare the logged SDRAM traffic with the expected ascending copy.
  task automatic checkCopy(input string tag, input logic [31:0] dst,
                           input logic [31:0] src, input int num);
    checkOutput({tag, "_numReads"}, rdLog.size(), num);
    checkOutput({tag, "_numWrites"}, wrAddrLog.size(), num);
    for (int i = 0; i < num; i++) begin
      logic [31:0] sa;
      sa = src + 32'(4 * i);
      if (i < rdLog.size()) checkOutput($sformatf("%s_rdAddr%0d", tag, i), rdLog[i], sa);
      if (i < wrAddrLog.size()) begin
        checkOutput($sformatf("%s_wrAddr%0d", tag, i), wrAddrLog[i], dst + 32'(4 * i));
        checkOutput($sformatf("%s_wrData%0d", tag, i), wrDataLog[i], sdramData(sa));
      end
    end
  endtask

  task automatic clearLogs();
    rdLog.delete();
    wrAddrLog.delete();
    wrDataLog.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    vec_t        vecs[14];
    logic [31:0] rd;
    int          st;
    int          rdBefore, wrBefore;

    rst             = 1'b1;
    slave_address   = '0;
    slave_read      = 1'b0;
    slave_write     = 1'b0;
    slave_writedata = '0;

    vecs[0]  = '{1'b1, 4'd1,  32'd6,          32'd0};
    vecs[1]  = '{1'b1, 4'd2,  32'd13,         32'd0};
    vecs[2]  = '{1'b1, 4'd3,  32'd5,          32'd0};
    vecs[3]  = '{1'b0, 4'd1,  32'd0,          32'd6};
    vecs[4]  = '{1'b0, 4'd2,  32'd0,          32'd13};
    vecs[5]  = '{1'b0, 4'd3,  32'd0,          32'd5};
    vecs[6]  = '{1'b0, 4'd0,  32'd0,          32'd0};
    vecs[7]  = '{1'b1, 4'd9,  32'hDEADBEEF,   32'd0};
    vecs[8]  = '{1'b0, 4'd9,  32'd0,          32'd0};
    vecs[9]  = '{1'b0, 4'd15, 32'd0,          32'd0};
    vecs[10] = '{1'b0, 4'd4,  32'd0,          32'd0};
    vecs[11] = '{1'b1, 4'd5,  32'h12345678,   32'd0};
    vecs[12] = '{1'b0, 4'd3,  32'd0,          32'd5};
    vecs[13] = '{1'b0, 4'd1,  32'd0,          32'd6};

    // Reset, then idle with no access
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    checkOutput("rstMasterRead", {31'd0, master_read}, 32'd0);
    checkOutput("rstMasterWrite", {31'd0, master_write}, 32'd0);
    checkOutput("rstWaitreq", {31'd0, slave_waitrequest}, 32'd0);
    checkOutput("rstAddr", master_address, 32'd0);
    checkOutput("rstWdata", master_writedata, 32'd0);
    checkOutput("rstRdata", slave_readdata, 32'd0);

    // Idle register accesses from the vector table
    for (int i = 0; i < 14; i++) applyStimulus(vecs[i], i);

    // Zero-wait copy of 5 words: 4 cycles per word plus DONE
    clearLogs();
    stallCycles = 0;
    rdvDelay    = 0;
    fixedData   = 1'b1;
    cpuWrite(4'd0, 32'hFFFFFFFF);
    cpuRead(4'd0, rd, st);
    checkOutput("copy1_stall", st, 32'd21);
    checkOutput("copy1_status", rd, 32'd0);
    checkCopy("copy1", 32'd6, 32'd13, 5);
    cpuRead(4'd1, rd, st);
    checkOutput("copy1_dst", rd, 32'd6);
    cpuRead(4'd2, rd, st);
    checkOutput("copy1_src", rd, 32'd13);
    cpuRead(4'd3, rd, st);
    checkOutput("copy1_num", rd, 32'd5);

    // num = 0: straight to DONE, no master traffic
    clearLogs();
    cpuWrite(4'd3, 32'd0);
    cpuWrite(4'd0, 32'd0);
    cpuRead(4'd0, rd, st);
    checkOutput("zero_stall", st, 32'd1);
    checkOutput("zero_status", rd, 32'd0);
    checkOutput("zero_reads", rdLog.size(), 32'd0);
    checkOutput("zero_writes", wrAddrLog.size(), 32'd0);

    // Wait states and slow read data, source wrapping past 2^32
    clearLogs();
    stallCycles = 3;
    rdvDelay    = 2;
    fixedData   = 1'b0;
    cpuWrite(4'd1, 32'h0000_1000);
    cpuWrite(4'd2, 32'hFFFF_FFF8);
    cpuWrite(4'd3, 32'd3);
    cpuWrite(4'd0, 32'd0);
    cpuRead(4'd0, rd, st);
    checkOutput("slow_stall", st, 32'd37);
    checkOutput("slow_status", rd, 32'd0);
    checkCopy("slow", 32'h0000_1000, 32'hFFFF_FFF8, 3);

    // Reset while the first write is being presented
    clearLogs();
    stallCycles = 3;
    rdvDelay    = 0;
    cpuWrite(4'd1, 32'h300);
    cpuWrite(4'd2, 32'h400);
    cpuWrite(4'd3, 32'd4);
    cpuWrite(4'd0, 32'd0);
    for (int k = 0; k < 200 && !master_write; k++) begin
      @(negedge clk);
      #1;
    end
    checkOutput("abort_reachPaste", {31'd0, master_write}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_read", {31'd0, master_read}, 32'd0);
    checkOutput("abort_write", {31'd0, master_write}, 32'd0);
    checkOutput("abort_addr", master_address, 32'd0);
    checkOutput("abort_wdata", master_writedata, 32'd0);
    rdBefore = rdLog.size();
    wrBefore = wrAddrLog.size();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checkOutput("abort_noNewReads", rdLog.size(), rdBefore);
    checkOutput("abort_noNewWrites", wrAddrLog.size(), wrBefore);
    checkOutput("abort_strobes", {30'd0, master_read, master_write}, 32'd0);
    cpuRead(4'd1, rd, st);
    checkOutput("abort_dst", rd, 32'd0);
    checkOutput("abort_idle", st, 32'd0);
    cpuRead(4'd2, rd, st);
    checkOutput("abort_src", rd, 32'd0);
    cpuRead(4'd3, rd, st);
    checkOutput("abort_num", rd, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
